// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-capable sharing of one
// FIFO write port among NUM_REQ valid/ready producers.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  fw_q, fw_d;
  logic [DATA_WIDTH-1:0] fwd_q, fwd_d;

  logic                  space_ok;
  logic                  found;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         sel;
  logic [GW-1:0]         next_ptr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REQ-1:0]    ready;
  logic [CW-1:0]         cnt_inc;

  // The registered write still in flight may consume the last slot.
  assign space_ok = !fifo_full && !(fw_q && fifo_almost_full);

  always_comb begin
    int j;
    logic [GW-1:0] jj;
    found = 1'b0;
    pick  = '0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = GW'(j);
      if (!found && req_valid[jj]) begin
        found = 1'b1;
        pick  = jj;
      end
    end
  end

  assign sel = (state_q == IDLE) ? pick : grant_q;

  assign next_ptr = (sel == GW'(NUM_REQ - 1)) ?
                    '0 : sel + GW'(1);

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == GW'(i))
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    fw_d     = 1'b0;
    fwd_d    = fwd_q;
    ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (found && space_ok) begin
          ready[pick] = 1'b1;
          fw_d        = 1'b1;
          fwd_d       = sel_data;
          grant_d     = pick;
          cnt_d       = CW'(1);
          if (MAX_BURST == 1) rr_ptr_d = next_ptr;
          else                state_d  = BURST;
        end
      end
      BURST: begin
        // A stall never ends the burst; only a
        // completed count or an idle producer does.
        if (space_ok) begin
          if (req_valid[grant_q]) begin
            ready[grant_q] = 1'b1;
            fw_d           = 1'b1;
            fwd_d          = sel_data;
            cnt_d          = cnt_inc;
            if (cnt_inc == CW'(MAX_BURST)) begin
              rr_ptr_d = next_ptr;
              state_d  = IDLE;
            end
          end else begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      fw_q     <= 1'b0;
      fwd_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      fw_q     <= fw_d;
      fwd_q    <= fwd_d;
    end
  end

  assign req_ready       = reset ? ready : '0;
  assign fifo_write      = fw_q;
  assign fifo_write_data = fwd_q;
  assign grant_id        = grant_q;
  assign busy            = (state_q == BURST);

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin write-side arbiter that shares one FIFO_simple_DP_RAM write port among NUM_REQ producers.
- Each producer uses a valid/ready handshake. The block sequences accepted words onto the FIFO write/write_data pins.
- A granted producer may hold the port for a burst of up to MAX_BURST words. The block throttles on the FIFO full and almost_full flags so no write is ever lost.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, word width; equals the FIFO's FIFO_DATA_WIDTH.
- MAX_BURST, 4, maximum consecutive words per grant (1..16).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  NUM_REQ  per-producer word valid.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i's data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer accept, combinational, one-hot or zero.
- fifo_write  output  1  registered FIFO write strobe.
- fifo_write_data  output  DATA_WIDTH  registered FIFO write data.
- fifo_full  input  1  FIFO full flag.
- fifo_almost_full  input  1  FIFO almost_full flag; the FIFO must be built with ALMOST_FULL_DEPTH >= 2.
- grant_id  output  clog2(NUM_REQ)  index of the current/last granted producer.
- busy  output  1  high while in state BURST.

Behaviour:
- Reset (reset=0, async): state=IDLE, fifo_write=0, fifo_write_data=0, grant_id=0, rr_ptr=0, burst_cnt=0. req_ready=0 while reset is asserted.
- Space check: space_ok = !fifo_full && !(fifo_write && fifo_almost_full). This guards the one in-flight registered write.
- Transfer: a transfer on producer i occurs when req_valid[i] && req_ready[i] at a clock edge. On the next cycle fifo_write=1 and fifo_write_data = that word. This is 1-cycle latency, one word per cycle max. fifo_write=0 in any cycle following no transfer.

States:
- IDLE:
  - If any req_valid and space_ok: pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Assert that index's req_ready combinationally and transfer the word this cycle.
  - grant_id<=index, burst_cnt<=1, go to BURST.
  - If MAX_BURST=1, go directly to the rotate step instead.
- BURST:
  - req_ready[grant_id] = req_valid[grant_id] && space_ok; all other ready bits are 0.
  - On each transfer, burst_cnt increments.
  - Rotate (rr_ptr<=grant_id+1 mod NUM_REQ, go to IDLE) when any of:
    - a transfer makes burst_cnt reach MAX_BURST;
    - req_valid[grant_id]=0 with space_ok=1 (producer ended early);
    - reset of burst.
  - If space_ok=0, stay in BURST and stall: ready low, burst_cnt frozen, grant retained. This holds even if the producer drops valid during the stall; only the rotate conditions above end it.
- Fairness: a producer that is continuously valid is granted within (NUM_REQ-1)*MAX_BURST + NUM_REQ transfer slots.
- A producer must hold req_data stable while req_valid=1 and ready=0. The arbiter never drops or duplicates words.
- Mid-operation reset: an in-flight fifo_write is cleared immediately; a partial burst is abandoned, with no further writes.
- grant_id holds its last value in IDLE.
- Read side of the FIFO is out of scope; full/almost_full may change at any cycle.

Test Plan:
- Single producer: reset, producer 0 sends 0x00..0x09 continuously -> fifo_write pulses 10 words in order. Bursts of 4,4,2 with one IDLE cycle between bursts. Data 0x00..0x09 arrives one cycle after each handshake.
- Round-robin: all 4 producers continuously valid, producer i data = 0x10*i + n -> grant order 0,1,2,3,0,... with 4-word bursts. FIFO sequence is 0x00-0x03, 0x10-0x13, 0x20-0x23, 0x30-0x33.
- Full throttling: FIFO model of depth 32 with no reads, producer 1 sends 40 words -> exactly 32 fifo_write pulses. No write while full=1; req_ready[1] stays 0 after word 32.
- Almost-full guard: force fifo_almost_full=1 in the cycle fifo_write=1 -> req_ready=0 that cycle, then resumes when almost_full=0.
- Early drop and fairness: producer 2 valid for 2 words then low, producer 3 valid -> burst 2 ends. Next grant goes to 3 (rr_ptr=3), not 0.
- Async reset mid-burst: assert reset after 2 of 4 words -> fifo_write=0, busy=0, grant_id=0 immediately without waiting for clk. After release, arbitration restarts from producer 0.
